// File: rtl/wb_multi_retire_pkg.sv
// Shared types for the multi-lane write-back stage: write-data source
// encodings and common scalar typedefs.
package wb_multi_retire_pkg;

    localparam int REN_S = 5;

    typedef enum logic [1:0] {
        WB_X   = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2,
        WB_CSR = 2'd3
    } wb_sel_e;

    typedef logic [7:0]       iid_t;
    typedef logic [31:0]      uint_x_t;
    typedef logic [REN_S-1:0] addr_t;

endpackage

// File: rtl/wb_multi_retire_if.sv
// Bus between the memory stage / decode side and the write-back stage.
// Lane and read-port fields are packed flat, lane 0 in the low bits.
interface wb_multi_retire_if #(
    parameter int XLEN       = 32,
    parameter int NUM_LANES  = 2,
    parameter int NUM_RPORTS = 2,
    parameter int IID_W      = 8
);
    logic [NUM_LANES-1:0]        wb_valid;
    logic [NUM_LANES*XLEN-1:0]   wb_pc;
    logic [NUM_LANES*IID_W-1:0]  wb_inst_id;
    logic [NUM_LANES*2-1:0]      wb_sel;
    logic [NUM_LANES-1:0]        wb_rf_wen;
    logic [NUM_LANES*5-1:0]      wb_addr;
    logic [NUM_LANES*XLEN-1:0]   wb_alu_out;
    logic [NUM_LANES*XLEN-1:0]   wb_mem_rdata;
    logic [NUM_LANES*XLEN-1:0]   wb_csr_rdata;
    logic [NUM_LANES*XLEN-1:0]   wb_wdata_out;
    logic [NUM_LANES-1:0]        wb_retire;
    logic [NUM_RPORTS*5-1:0]     rd_addr;
    logic [NUM_RPORTS*XLEN-1:0]  rd_data;

    modport master (
        output wb_valid, wb_pc, wb_inst_id, wb_sel, wb_rf_wen, wb_addr,
               wb_alu_out, wb_mem_rdata, wb_csr_rdata, rd_addr,
        input  wb_wdata_out, wb_retire, rd_data
    );

    modport slave (
        input  wb_valid, wb_pc, wb_inst_id, wb_sel, wb_rf_wen, wb_addr,
               wb_alu_out, wb_mem_rdata, wb_csr_rdata, rd_addr,
        output wb_wdata_out, wb_retire, rd_data
    );
endinterface

// File: rtl/wb_lane_sel.sv
// One retire lane: picks the write-back value and flags whether the
// instruction id differs from the one this lane saw last.
module wb_lane_sel
    import wb_multi_retire_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter int               IID_W     = 8,
    parameter logic [IID_W-1:0] IID_RESET = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [XLEN-1:0]  pc,
    input  logic [IID_W-1:0] inst_id,
    input  logic [1:0]       sel,
    input  logic [XLEN-1:0]  alu_out,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic [XLEN-1:0]  csr_rdata,
    output logic [XLEN-1:0]  wdata,
    output logic             is_new
);

    logic [IID_W-1:0] saved_id;

    always_comb begin
        wdata = alu_out;
        case (wb_sel_e'(sel))
            WB_MEM:  wdata = mem_rdata;
            WB_PC:   wdata = pc + XLEN'(4);
            WB_CSR:  wdata = csr_rdata;
            default: wdata = alu_out;
        endcase
    end

    assign is_new = valid && (inst_id != saved_id);

    // A stalled instruction keeps presenting its id; remembering it even
    // when it is not new is what suppresses the repeat.
    always_ff @(posedge clk) begin
        if (!rst_n)
            saved_id <= IID_RESET;
        else if (valid)
            saved_id <= inst_id;
    end

endmodule

// File: rtl/wb_multi_retire.sv
// Multi-lane write-back stage: owns the register file, bypasses same-cycle
// commits to the read ports, counts retirements and latches program exit.
module wb_multi_retire
    import wb_multi_retire_pkg::*;
#(
    parameter int               XLEN       = 32,
    parameter int               NUM_LANES  = 2,
    parameter int               NUM_RPORTS = 2,
    parameter int               IID_W      = 8,
    parameter logic [IID_W-1:0] IID_RESET  = '1,
    parameter logic [XLEN-1:0]  EXIT_PC    = 32'hffffff00,
    parameter logic [XLEN-1:0]  SP_INIT    = 32'h00007500,
    parameter logic [XLEN-1:0]  REG_FILL   = '1,
    parameter int               CNT_W      = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_multi_retire_if.slave bus,
    output logic [CNT_W-1:0] inst_count,
    output logic             exit
);

    localparam int NREGS = 32;

    logic [XLEN-1:0]      rf [NREGS];
    logic [NUM_LANES-1:0] is_new;
    logic [NUM_LANES-1:0] commit;
    logic [XLEN-1:0]      wdata [NUM_LANES];
    addr_t                waddr [NUM_LANES];
    logic [CNT_W-1:0]     cnt_inc;
    logic                 exit_hit;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        wb_lane_sel #(
            .XLEN      (XLEN),
            .IID_W     (IID_W),
            .IID_RESET (IID_RESET)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .valid     (bus.wb_valid[l]),
            .pc        (bus.wb_pc[l*XLEN +: XLEN]),
            .inst_id   (bus.wb_inst_id[l*IID_W +: IID_W]),
            .sel       (bus.wb_sel[l*2 +: 2]),
            .alu_out   (bus.wb_alu_out[l*XLEN +: XLEN]),
            .mem_rdata (bus.wb_mem_rdata[l*XLEN +: XLEN]),
            .csr_rdata (bus.wb_csr_rdata[l*XLEN +: XLEN]),
            .wdata     (wdata[l]),
            .is_new    (is_new[l])
        );

        assign waddr[l]  = bus.wb_addr[l*REN_S +: REN_S];
        assign commit[l] = is_new[l] & bus.wb_rf_wen[l] & (waddr[l] != '0);
        assign bus.wb_wdata_out[l*XLEN +: XLEN] = wdata[l];
    end

    assign bus.wb_retire = is_new;

    // Lanes are walked oldest first so the youngest writer to a register
    // lands last and wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++)
                rf[r] <= (r == 0) ? '0 : ((r == 2) ? SP_INIT : REG_FILL);
        end else begin
            for (int l = 0; l < NUM_LANES; l++)
                if (commit[l])
                    rf[waddr[l]] <= wdata[l];
        end
    end

    always_comb begin
        bus.rd_data = '0;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            logic [XLEN-1:0] rv;
            addr_t           ra;
            ra = bus.rd_addr[p*REN_S +: REN_S];
            rv = rf[ra];
            for (int l = 0; l < NUM_LANES; l++)
                if (commit[l] && (waddr[l] == ra))
                    rv = wdata[l];
            if (ra == '0)
                rv = '0;
            bus.rd_data[p*XLEN +: XLEN] = rv;
        end
    end

    always_comb begin
        cnt_inc  = '0;
        exit_hit = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            cnt_inc = cnt_inc + CNT_W'(is_new[l]);
            if (is_new[l] && (bus.wb_pc[l*XLEN +: XLEN] == EXIT_PC))
                exit_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_count <= '0;
            exit       <= 1'b0;
        end else begin
            inst_count <= inst_count + cnt_inc;
            if (exit_hit)
                exit <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_multi_retire.sv
// Directed bench for wb_multi_retire: reset values, id dedup, lane conflict
// and bypass, source selects, x0 handling, exit latching and mid-run reset.
module tb_wb_multi_retire;
    import wb_multi_retire_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [63:0] inst_count;
    logic        exit;

    int          checks;
    int          failures;
    logic [63:0] exp_count;
    logic [31:0] rv;

    wb_multi_retire_if #(.XLEN(32), .NUM_LANES(2), .NUM_RPORTS(2), .IID_W(8)) bus ();

    wb_multi_retire dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .inst_count (inst_count),
        .exit       (exit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_valid     = '0;
        bus.wb_pc        = '0;
        bus.wb_inst_id   = '0;
        bus.wb_sel       = '0;
        bus.wb_rf_wen    = '0;
        bus.wb_addr      = '0;
        bus.wb_alu_out   = '0;
        bus.wb_mem_rdata = '0;
        bus.wb_csr_rdata = '0;
        bus.rd_addr      = '0;
    endtask

    task automatic set_lane(input int l, input logic [31:0] pc, input logic [7:0] id,
                            input logic [1:0] sel, input logic wen, input logic [4:0] rd,
                            input logic [31:0] alu, input logic [31:0] mem,
                            input logic [31:0] csr);
        bus.wb_valid[l]               = 1'b1;
        bus.wb_pc[l*32 +: 32]         = pc;
        bus.wb_inst_id[l*8 +: 8]      = id;
        bus.wb_sel[l*2 +: 2]          = sel;
        bus.wb_rf_wen[l]              = wen;
        bus.wb_addr[l*5 +: 5]         = rd;
        bus.wb_alu_out[l*32 +: 32]    = alu;
        bus.wb_mem_rdata[l*32 +: 32]  = mem;
        bus.wb_csr_rdata[l*32 +: 32]  = csr;
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
        bus.rd_addr[4:0] = a;
        #1;
        d = bus.rd_data[31:0];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
        read_reg(5'd0, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("[TB] FAIL reset_x0 got=%h exp=%h", rv, 32'h0); end
        read_reg(5'd1, rv);
        checks++;
        if (rv !== 32'hffffffff) begin failures++; $display("[TB] FAIL reset_x1 got=%h exp=%h", rv, 32'hffffffff); end
        read_reg(5'd2, rv);
        checks++;
        if (rv !== 32'h00007500) begin failures++; $display("[TB] FAIL reset_x2 got=%h exp=%h", rv, 32'h00007500); end
        checks++;
        if (inst_count !== 64'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", inst_count); end
        checks++;
        if (exit !== 1'b0) begin failures++; $display("[TB] FAIL reset_exit got=%b exp=0", exit); end
        exp_count = 64'd0;
    endtask

    task automatic test_dedup();
        idle();
        set_lane(0, 32'h40, 8'd5, WB_X, 1'b1, 5'd3, 32'h1234, 32'h0, 32'h0);
        bus.rd_addr[9:5] = 5'd3;
        #1;
        checks++;
        if (bus.wb_retire !== 2'b01) begin failures++; $display("[TB] FAIL dedup_retire1 got=%b exp=01", bus.wb_retire); end
        checks++;
        if (bus.rd_data[63:32] !== 32'h1234) begin failures++; $display("[TB] FAIL dedup_bypass got=%h exp=%h", bus.rd_data[63:32], 32'h1234); end
        tick();
        exp_count += 1;
        checks++;
        if (bus.wb_retire !== 2'b00) begin failures++; $display("[TB] FAIL dedup_retire2 got=%b exp=00", bus.wb_retire); end
        read_reg(5'd3, rv);
        checks++;
        if (rv !== 32'h1234) begin failures++; $display("[TB] FAIL dedup_x3 got=%h exp=%h", rv, 32'h1234); end
        tick();
        checks++;
        if (bus.wb_retire !== 2'b00) begin failures++; $display("[TB] FAIL dedup_retire3 got=%b exp=00", bus.wb_retire); end
        tick();
        checks++;
        if (inst_count !== exp_count) begin failures++; $display("[TB] FAIL dedup_count got=%0d exp=%0d", inst_count, exp_count); end
        idle();
    endtask

    task automatic test_conflict_bypass();
        idle();
        set_lane(0, 32'h44, 8'd6, WB_X, 1'b1, 5'd7, 32'hA, 32'h0, 32'h0);
        set_lane(1, 32'h48, 8'd7, WB_X, 1'b1, 5'd7, 32'hB, 32'h0, 32'h0);
        bus.rd_addr = {5'd7, 5'd0};
        #1;
        checks++;
        if (bus.rd_data[63:32] !== 32'hB) begin failures++; $display("[TB] FAIL conflict_bypass got=%h exp=%h", bus.rd_data[63:32], 32'hB); end
        checks++;
        if (bus.rd_data[31:0] !== 32'h0) begin failures++; $display("[TB] FAIL conflict_port0_x0 got=%h exp=0", bus.rd_data[31:0]); end
        checks++;
        if (bus.wb_retire !== 2'b11) begin failures++; $display("[TB] FAIL conflict_retire got=%b exp=11", bus.wb_retire); end
        tick();
        exp_count += 2;
        idle();
        read_reg(5'd7, rv);
        checks++;
        if (rv !== 32'hB) begin failures++; $display("[TB] FAIL conflict_x7 got=%h exp=%h", rv, 32'hB); end
        checks++;
        if (inst_count !== exp_count) begin failures++; $display("[TB] FAIL conflict_count got=%0d exp=%0d", inst_count, exp_count); end
    endtask

    task automatic test_sel();
        idle();
        set_lane(0, 32'h50, 8'd13, WB_MEM, 1'b0, 5'd4, 32'h11, 32'h22, 32'h33);
        set_lane(1, 32'h54, 8'd14, WB_CSR, 1'b0, 5'd4, 32'h44, 32'h55, 32'h66);
        #1;
        checks++;
        if (bus.wb_wdata_out[31:0] !== 32'h22) begin failures++; $display("[TB] FAIL sel_mem got=%h exp=%h", bus.wb_wdata_out[31:0], 32'h22); end
        checks++;
        if (bus.wb_wdata_out[63:32] !== 32'h66) begin failures++; $display("[TB] FAIL sel_csr got=%h exp=%h", bus.wb_wdata_out[63:32], 32'h66); end
        tick();
        exp_count += 2;
        idle();
        read_reg(5'd4, rv);
        checks++;
        if (rv !== 32'hffffffff) begin failures++; $display("[TB] FAIL sel_nowen_x4 got=%h exp=%h", rv, 32'hffffffff); end
    endtask

    task automatic test_x0_pc();
        idle();
        set_lane(1, 32'h100, 8'd8, WB_PC, 1'b1, 5'd0, 32'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (bus.wb_wdata_out[63:32] !== 32'h104) begin failures++; $display("[TB] FAIL pc_sel got=%h exp=%h", bus.wb_wdata_out[63:32], 32'h104); end
        checks++;
        if (bus.wb_retire !== 2'b10) begin failures++; $display("[TB] FAIL gap_retire got=%b exp=10", bus.wb_retire); end
        checks++;
        if (bus.rd_data[31:0] !== 32'h0) begin failures++; $display("[TB] FAIL x0_bypass got=%h exp=0", bus.rd_data[31:0]); end
        tick();
        exp_count += 1;
        idle();
        read_reg(5'd0, rv);
        checks++;
        if (rv !== 32'h0) begin failures++; $display("[TB] FAIL x0_after got=%h exp=0", rv); end
        set_lane(1, 32'h100, 8'd9, WB_PC, 1'b1, 5'd9, 32'h0, 32'h0, 32'h0);
        tick();
        exp_count += 1;
        idle();
        read_reg(5'd9, rv);
        checks++;
        if (rv !== 32'h104) begin failures++; $display("[TB] FAIL pc_x9 got=%h exp=%h", rv, 32'h104); end
        set_lane(1, 32'hfffffffc, 8'd15, WB_PC, 1'b0, 5'd9, 32'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (bus.wb_wdata_out[63:32] !== 32'h0) begin failures++; $display("[TB] FAIL pc_wrap got=%h exp=0", bus.wb_wdata_out[63:32]); end
        tick();
        exp_count += 1;
        checks++;
        if (inst_count !== exp_count) begin failures++; $display("[TB] FAIL pc_count got=%0d exp=%0d", inst_count, exp_count); end
        idle();
    endtask

    task automatic test_exit();
        idle();
        set_lane(1, 32'hffffff00, 8'd15, WB_X, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        checks++;
        if (exit !== 1'b0) begin failures++; $display("[TB] FAIL exit_repeat_id got=%b exp=0", exit); end
        set_lane(1, 32'hffffff00, 8'd16, WB_X, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        exp_count += 1;
        idle();
        checks++;
        if (exit !== 1'b1) begin failures++; $display("[TB] FAIL exit_set got=%b exp=1", exit); end
        repeat (10) tick();
        checks++;
        if (exit !== 1'b1) begin failures++; $display("[TB] FAIL exit_sticky got=%b exp=1", exit); end
        checks++;
        if (inst_count !== exp_count) begin failures++; $display("[TB] FAIL exit_count got=%0d exp=%0d", inst_count, exp_count); end
    endtask

    task automatic test_reset_mid();
        idle();
        set_lane(0, 32'h60, 8'd11, WB_X, 1'b1, 5'd5, 32'h55, 32'h0, 32'h0);
        set_lane(1, 32'h64, 8'd12, WB_X, 1'b1, 5'd5, 32'h66, 32'h0, 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_count = 64'd0;
        bus.wb_valid = 2'b00;
        read_reg(5'd5, rv);
        checks++;
        if (rv !== 32'hffffffff) begin failures++; $display("[TB] FAIL rstmid_x5 got=%h exp=%h", rv, 32'hffffffff); end
        checks++;
        if (inst_count !== 64'd0) begin failures++; $display("[TB] FAIL rstmid_count got=%0d exp=0", inst_count); end
        checks++;
        if (exit !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_exit got=%b exp=0", exit); end
        bus.wb_valid = 2'b11;
        #1;
        checks++;
        if (bus.wb_retire !== 2'b11) begin failures++; $display("[TB] FAIL rstmid_retire got=%b exp=11", bus.wb_retire); end
        tick();
        exp_count += 2;
        idle();
        read_reg(5'd5, rv);
        checks++;
        if (rv !== 32'h66) begin failures++; $display("[TB] FAIL rstmid_x5_after got=%h exp=%h", rv, 32'h66); end
        checks++;
        if (inst_count !== exp_count) begin failures++; $display("[TB] FAIL rstmid_count2 got=%0d exp=%0d", inst_count, exp_count); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_count = 64'd0;
        rst_n     = 1'b0;
        idle();
        repeat (2) tick();
        test_reset();
        test_dedup();
        test_conflict_bypass();
        test_sel();
        test_x0_pc();
        test_exit();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
